adder_result_collector: RTL and testbench

Downstream stage of the 4-bit adder. Captures every valid 7-bit sum/carry result the adder produces and buffers it in a small synchronous FIFO. Presents results to a consumer (scoreboard/bus stage) over a valid/ready handshake. Keeps a running total of accepted results and a count of results dropped when the buffer was full.

---
 rtl/adder_pkg.sv | 10 +
 rtl/adder_result_collector_sync_fifo_ptr.sv | 80 ++++++++
 rtl/adder_result_collector.sv | 107 ++++++++++
 tb/tb_adder_result_collector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared adder definitions: operand width, result width and the result type
// used by the adder, its interface and the downstream collector.
package adder_pkg;

    localparam int unsigned ADDER_OP_W = 4;
    localparam int unsigned DATA_W     = 7;

    typedef logic [DATA_W-1:0] adder_result_t;

endpackage : adder_pkg

// File: rtl/adder_result_collector_sync_fifo_ptr.sv
// Pointer / occupancy bookkeeping for a synchronous FIFO of DEPTH entries.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   push, pop        - qualified write / read strobes for this cycle
//   wr_ptr, rd_ptr   - next write slot / current head slot
//   count            - occupancy 0..DEPTH
//   full, empty      - count == DEPTH / count == 0
//   valid            - head holds data (registered complement of empty)
module sync_fifo_ptr #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             valid_q, valid_d;

    // Next-state: pointers wrap naturally, flags derived from next count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = full_q;
    assign empty  = empty_q;
    assign valid  = valid_q;

endmodule : sync_fifo_ptr

// File: rtl/adder_result_collector.sv
// Buffers adder results in a show-ahead FIFO, hands them to a consumer over
// valid/ready, and tracks a running total plus a saturating drop counter.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid, in_sum      - adder result stream (no backpressure)
//   out_valid, out_ready  - consumer handshake; out_sum is the FIFO head
//   count, full, empty    - FIFO occupancy status
//   total                 - wrapping sum of every accepted result
//   drop_cnt, overflow    - results lost while full; sticky loss flag
module adder_result_collector
    import adder_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  adder_result_t            in_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output adder_result_t            out_sum,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [ACC_W-1:0]         total,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             push;
    logic             drop;

    adder_result_t    mem [DEPTH];

    logic [ACC_W-1:0]  total_q, total_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              overflow_q, overflow_d;

    // A full FIFO still accepts a write when the head leaves on the same edge
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    sync_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty),
        .valid  (out_valid)
    );

    // Storage needs no reset; contents are only observed behind out_valid
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= in_sum;
        end
    end

    assign out_sum = mem[rd_ptr];

    // Accumulator and loss tracking
    always_comb begin
        total_d    = total_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        if (push) begin
            total_d = total_q + ACC_W'(in_sum);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            total_q    <= total_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    assign total    = total_q;
    assign drop_cnt = drop_q;
    assign overflow = overflow_q;

endmodule : adder_result_collector

// File: tb/tb_adder_result_collector.sv
// Randomised scoreboard bench for adder_result_collector.
`timescale 1ns/1ps
module tb_adder_result_collector;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned DROP_W = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [6:0]           in_sum;
    logic                 out_valid;
    logic                 out_ready;
    logic [6:0]           out_sum;
    logic [3:0]           count;
    logic                 full;
    logic                 empty;
    logic [ACC_W-1:0]     total;
    logic [DROP_W-1:0]    drop_cnt;
    logic                 overflow;

    always #5 clk = ~clk;

    adder_result_collector #(
        .DEPTH  (DEPTH),
        .ACC_W  (ACC_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .total     (total),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // Reference: an occupancy count, a queue of results the consumer should
    // see in order, and plain-arithmetic totals.
    int         m_cnt   = 0;
    int         m_total = 0;
    int         m_drop  = 0;
    bit         m_ovf   = 1'b0;
    logic [6:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model updates on each active edge from the stable inputs
    always @(posedge clk) begin
        bit pop_m;
        bit push_m;
        if (reset) begin
            m_cnt   = 0;
            m_total = 0;
            m_drop  = 0;
            m_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            pop_m  = (m_cnt > 0) && (out_ready === 1'b1);
            push_m = (in_valid === 1'b1) && ((m_cnt < int'(DEPTH)) || pop_m);
            if (push_m) begin
                exp_q.push_back(in_sum);
                m_total = (m_total + int'(in_sum)) % 65536;
            end else if (in_valid === 1'b1) begin
                if (m_drop < 255) m_drop++;
                m_ovf = 1'b1;
            end
            m_cnt = m_cnt + int'(push_m) - int'(pop_m);
        end
    end

    // Monitor: status every cycle, data whenever a handshake is about to occur
    always @(negedge clk) begin
        if (mon_en) begin
            check("count",     32'(count),     32'(m_cnt));
            check("empty",     32'(empty),     32'(m_cnt == 0));
            check("full",      32'(full),      32'(m_cnt == int'(DEPTH)));
            check("out_valid", 32'(out_valid), 32'(m_cnt != 0));
            check("total",     32'(total),     32'(m_total));
            check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
            check("overflow",  32'(overflow),  32'(m_ovf));
            if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_pop: got handshake with out_sum 0x%0h expected no data at %0t", out_sum, $time);
                end else begin
                    check("out_sum", 32'(out_sum), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input bit v, input logic [6:0] s, input bit r, input bit rst = 1'b0);
        reset     = rst;
        in_valid  = v;
        in_sum    = s;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] s;

        step(1'b0, 7'h00, 1'b0, 1'b1);
        step(1'b0, 7'h00, 1'b0, 1'b1);
        mon_en = 1'b1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);

        // Three results held with no consumer
        step(1'b1, 7'h05, 1'b0);
        step(1'b1, 7'h1E, 1'b0);
        step(1'b1, 7'h7F, 1'b0);
        check("tp1_count", 32'(count), 32'd3);
        check("tp1_valid", 32'(out_valid), 32'd1);
        check("tp1_head",  32'(out_sum), 32'h05);
        check("tp1_total", 32'(total), 32'h00A2);
        check("tp1_empty", 32'(empty), 32'd0);

        // Fill, then two drops
        step(1'b0, 7'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b1, 7'(i), 1'b0);
        step(1'b1, 7'h10, 1'b0);
        step(1'b1, 7'h11, 1'b0);
        check("tp2_full",  32'(full), 32'd1);
        check("tp2_count", 32'(count), 32'd8);
        check("tp2_drop",  32'(drop_cnt), 32'd2);
        check("tp2_ovf",   32'(overflow), 32'd1);
        check("tp2_total", 32'(total), 32'd36);
        check("tp2_head",  32'(out_sum), 32'd1);

        // Push and pop together while full
        step(1'b1, 7'h33, 1'b1);
        check("tp3_count", 32'(count), 32'd8);
        check("tp3_drop",  32'(drop_cnt), 32'd2);
        check("tp3_head",  32'(out_sum), 32'd2);
        check("tp3_total", 32'(total), 32'd87);
        repeat (10) step(1'b0, 7'h00, 1'b1);
        check("tp3_drained", 32'(empty), 32'd1);

        // Streaming: every result is visible one cycle after it is pushed
        step(1'b0, 7'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            s = 7'($urandom);
            step(1'b1, s, 1'b1);
            check("tp4_count", 32'(count), 32'd1);
            check("tp4_head",  32'(out_sum), 32'(s));
        end
        step(1'b0, 7'h00, 1'b1);
        check("tp4_empty", 32'(empty), 32'd1);

        // Total wraps at 2^16
        step(1'b0, 7'h00, 1'b0, 1'b1);
        repeat (600) step(1'b1, 7'h7F, 1'b1);
        check("tp5_total", 32'(total), 32'd10664);
        check("tp5_drop",  32'(drop_cnt), 32'd0);

        // Drop counter saturates
        step(1'b0, 7'h00, 1'b0, 1'b1);
        repeat (308) step(1'b1, 7'($urandom), 1'b0);
        check("tp6_drop",  32'(drop_cnt), 32'd255);
        check("tp6_ovf",   32'(overflow), 32'd1);
        check("tp6_count", 32'(count), 32'd8);

        // Random traffic: producer-heavy, then consumer-heavy
        step(1'b0, 7'h00, 1'b0, 1'b1);
        repeat (200) step($urandom_range(0, 9) < 8, 7'($urandom), $urandom_range(0, 9) < 3);
        repeat (200) step($urandom_range(0, 9) < 3, 7'($urandom), $urandom_range(0, 9) < 8);
        repeat (10) step(1'b0, 7'h00, 1'b1);

        // Reset mid-operation with a handshake pending
        step(1'b0, 7'h00, 1'b0, 1'b1);
        repeat (5) step(1'b1, 7'($urandom_range(1, 127)), 1'b0);
        check("tp7_pre_count", 32'(count), 32'd5);
        step(1'b1, 7'h2A, 1'b1, 1'b1);
        check("tp7_count", 32'(count), 32'd0);
        check("tp7_valid", 32'(out_valid), 32'd0);
        check("tp7_total", 32'(total), 32'd0);
        check("tp7_drop",  32'(drop_cnt), 32'd0);
        check("tp7_ovf",   32'(overflow), 32'd0);
        step(1'b0, 7'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_adder_result_collector
